// File: rtl/lmsm_expander.sv
// lmsm_expander: decode-front stage that sits between the IF/ID register and
// the control decoder. Ordinary instructions pass through with one cycle of
// latency. Each LM/SM is expanded into one LW/SW micro-op per selected
// register, and fetch is back-pressured while the expansion runs.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_instr  instruction from IF/ID, with its PC in in_pc
//   in_ready           instruction accepted this cycle (combinational)
//   out_valid/out_instr/out_pc/out_last  registered micro-op stream
//   stall              downstream hold; the outputs do not change
//   flush              synchronous kill of any in-flight output/expansion
//
// Build option: define LMSM_BASE_LAST_EN to defer an LM's base-register load
// to the end of the sequence, so every other micro-op sees the original base.
//
// state   | meaning
// S_IDLE  | may accept; outputs hold a pass-through or nothing
// S_EXPAND| emitting LW/SW micro-ops; fetch held off
module lmsm_expander (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [15:0] in_instr,
  input  logic [15:0] in_pc,
  output logic        in_ready,
  output logic        out_valid,
  output logic [15:0] out_instr,
  output logic [15:0] out_pc,
  output logic        out_last,
  input  logic        stall,
  input  logic        flush
);

  typedef enum logic {S_IDLE, S_EXPAND} state_t;

  state_t      state_q;
  logic [7:0]  mask_q;     // registers still to emit, including the one shown
  logic [7:0]  orig_q;     // original imm8, source of the memory slot offsets
  logic [2:0]  base_q;
  logic        is_sm_q;
  logic        out_valid_q, out_last_q;
  logic [15:0] out_instr_q, out_pc_q;

  logic        fire, accept, in_is_lmsm;
  logic        sel_sm;
  logic [2:0]  sel_base, nxt_r;
  logic [7:0]  sel_orig, sel_rem, skip;
  logic [15:0] nxt_instr;
  logic        nxt_last;

  // Lowest set bit of rem, preferring bits outside skip when any exist.
  function automatic logic [2:0] pick(input logic [7:0] rem, input logic [7:0] skip_m);
    logic [7:0] eff;
    eff = rem & ~skip_m;
    if (eff == 8'd0) eff = rem;
    pick = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (eff[i]) pick = i[2:0];
  endfunction

  // Slot of register r: how many selected registers sit below it.
  function automatic logic [2:0] off_of(input logic [7:0] orig, input logic [2:0] r);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 8; i++)
      if (orig[i] && (3'(i) < r)) n = n + 3'd1;
    off_of = n;
  endfunction

  assign fire       = out_valid_q & ~stall;
  assign in_ready   = (state_q == S_IDLE) & (~out_valid_q | ~stall) & ~flush;
  assign accept     = in_valid & in_ready;
  assign in_is_lmsm = (in_instr[15:13] == 3'b011);

  // One micro-op generator serves both the first op (from the incoming
  // instruction) and every following op (from the latched context).
  always_comb begin
    if (state_q == S_IDLE) begin
      sel_sm   = in_instr[12];
      sel_base = in_instr[11:9];
      sel_orig = in_instr[7:0];
      sel_rem  = in_instr[7:0];
    end else begin
      sel_sm   = is_sm_q;
      sel_base = base_q;
      sel_orig = orig_q;
      sel_rem  = mask_q & ~(8'b1 << out_instr_q[11:9]);
    end
    skip = 8'd0;
`ifdef LMSM_BASE_LAST_EN
    if (!sel_sm && sel_orig[sel_base]) skip = 8'b1 << sel_base;
`endif
    nxt_r     = pick(sel_rem, skip);
    nxt_instr = {3'b010, sel_sm, nxt_r, sel_base, 3'b000, off_of(sel_orig, nxt_r)};
    nxt_last  = ((sel_rem & (sel_rem - 8'd1)) == 8'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mask_q      <= 8'd0;
      orig_q      <= 8'd0;
      base_q      <= 3'd0;
      is_sm_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_instr_q <= 16'd0;
      out_pc_q    <= 16'd0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      state_q     <= S_IDLE;
      mask_q      <= 8'd0;
    end else if (state_q == S_IDLE) begin
      if (accept) begin
        if (!in_is_lmsm) begin
          out_valid_q <= 1'b1;
          out_last_q  <= 1'b1;
          out_instr_q <= in_instr;
          out_pc_q    <= in_pc;
        end else if (in_instr[7:0] == 8'd0) begin
          out_valid_q <= 1'b0;
          out_last_q  <= 1'b0;
        end else begin
          out_valid_q <= 1'b1;
          out_last_q  <= nxt_last;
          out_instr_q <= nxt_instr;
          out_pc_q    <= in_pc;
          mask_q      <= in_instr[7:0];
          orig_q      <= in_instr[7:0];
          base_q      <= in_instr[11:9];
          is_sm_q     <= in_instr[12];
          state_q     <= S_EXPAND;
        end
      end else if (fire) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end else if (fire) begin
      if (sel_rem != 8'd0) begin
        out_instr_q <= nxt_instr;
        out_last_q  <= nxt_last;
        mask_q      <= sel_rem;
      end else begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
        mask_q      <= 8'd0;
        state_q     <= S_IDLE;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_lmsm_expander.sv
module tb_lmsm_expander;
  logic        clk, rst_n, in_valid, in_ready, out_valid, out_last, stall, flush;
  logic [15:0] in_instr, in_pc, out_instr, out_pc;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
    logic        last;
    logic        lmsm;
  } uop_t;
  uop_t q[$];

  lmsm_expander dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
    .in_ready(in_ready), .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_last(out_last), .stall(stall), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: list the micro-ops an instruction must produce.
  task automatic push_expansion(input logic [15:0] instr, input logic [15:0] pc);
    int regs[$];
    uop_t u;
    logic [3:0] opc;
    logic [7:0] imm;
    int ra, off;
    logic defer;
    opc = instr[15:12];
    imm = instr[7:0];
    ra  = int'(instr[11:9]);
    if (opc != 4'h6 && opc != 4'h7) begin
      u.instr = instr; u.pc = pc; u.last = 1'b1; u.lmsm = 1'b0;
      q.push_back(u);
      return;
    end
    defer = 1'b0;
`ifdef LMSM_BASE_LAST_EN
    defer = (opc == 4'h6) && imm[ra];
`endif
    for (int i = 0; i < 8; i++)
      if (imm[i] && !(defer && i == ra)) regs.push_back(i);
    if (defer) regs.push_back(ra);
    for (int k = 0; k < regs.size(); k++) begin
      off = 0;
      for (int j = 0; j < regs[k]; j++) if (imm[j]) off++;
      u.instr = {(opc == 4'h6) ? 4'h4 : 4'h5, 3'(regs[k]), 3'(ra), 3'b000, 3'(off)};
      u.pc    = pc;
      u.last  = (k == regs.size() - 1);
      u.lmsm  = 1'b1;
      q.push_back(u);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({out_valid, out_last, out_instr, out_pc} !== 34'd0) begin
      errors++; $display("FAIL reset_outputs: got v=%b l=%b i=%h pc=%h, want all 0", out_valid, out_last, out_instr, out_pc);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_passthrough();
    @(negedge clk); in_valid = 1'b1; in_instr = 16'h1234; in_pc = 16'h0040; #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL pass_ready: got %b want 1", in_ready); end
    @(negedge clk); in_valid = 1'b0; #1;
    checks++;
    if ({out_valid, out_last, in_ready, out_instr, out_pc} !== {3'b111, 16'h1234, 16'h0040}) begin
      errors++; $display("FAIL pass_out: got v=%b l=%b r=%b i=%h pc=%h, want 1 1 1 1234 0040", out_valid, out_last, in_ready, out_instr, out_pc);
    end
    @(negedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL pass_drain: got %b want 0", out_valid); end
  endtask

  task automatic run_seq(input logic [15:0] instr, input logic [15:0] pc, input logic [15:0] e0,
                         input logic [15:0] e1, input logic [15:0] e2, input string name);
    logic [15:0] exp_i [0:2];
    exp_i[0] = e0; exp_i[1] = e1; exp_i[2] = e2;
    @(negedge clk); in_valid = 1'b1; in_instr = instr; in_pc = pc;
    @(negedge clk); in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if ({out_valid, out_last, in_ready, out_instr, out_pc} !== {1'b1, (k == 2), 1'b0, exp_i[k], pc}) begin
        errors++; $display("FAIL %s_op%0d: got v=%b l=%b r=%b i=%h pc=%h, want 1 %b 0 %h %h",
                           name, k, out_valid, out_last, in_ready, out_instr, out_pc, (k == 2), exp_i[k], pc);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL %s_end: got v=%b r=%b want 0 1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_lm_basic();
    run_seq(16'h640B, 16'h0100, 16'h4080, 16'h4281, 16'h4682, "lm640b");
  endtask

  task automatic test_base_overlap();
`ifdef LMSM_BASE_LAST_EN
    run_seq(16'h6207, 16'h0200, 16'h4040, 16'h4442, 16'h4241, "lm6207");
`else
    run_seq(16'h6207, 16'h0200, 16'h4040, 16'h4241, 16'h4442, "lm6207");
`endif
  endtask

  task automatic test_sm_stall();
    @(negedge clk); in_valid = 1'b1; in_instr = 16'h7280; in_pc = 16'h0300;
    @(negedge clk); in_valid = 1'b0; stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if ({out_valid, out_last, in_ready, out_instr} !== {3'b110, 16'h5E40}) begin
        errors++; $display("FAIL sm_stall%0d: got v=%b l=%b r=%b i=%h, want 1 1 0 5e40", k, out_valid, out_last, in_ready, out_instr);
      end
      @(negedge clk);
    end
    stall = 1'b0; #1;
    checks++;
    if ({out_valid, in_ready, out_instr} !== {2'b10, 16'h5E40}) begin
      errors++; $display("FAIL sm_release: got v=%b r=%b i=%h want 1 0 5e40", out_valid, in_ready, out_instr);
    end
    @(negedge clk); #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL sm_after: got v=%b r=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_zero_mask();
    @(negedge clk); in_valid = 1'b1; in_instr = 16'h6400; in_pc = 16'h0400;
    @(negedge clk); in_instr = 16'h0ABC; in_pc = 16'h0402; #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL zero_mask: got v=%b r=%b want 0 1", out_valid, in_ready);
    end
    @(negedge clk); in_valid = 1'b0; #1;
    checks++;
    if ({out_valid, out_last, out_instr, out_pc} !== {2'b11, 16'h0ABC, 16'h0402}) begin
      errors++; $display("FAIL zero_follow: got v=%b l=%b i=%h pc=%h want 1 1 0abc 0402", out_valid, out_last, out_instr, out_pc);
    end
    @(negedge clk);
  endtask

  task automatic test_flush();
    @(negedge clk); in_valid = 1'b1; in_instr = 16'h640B; in_pc = 16'h0500;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({out_valid, out_instr} !== {1'b1, 16'h4281}) begin
      errors++; $display("FAIL flush_pre: got v=%b i=%h want 1 4281", out_valid, out_instr);
    end
    flush = 1'b1;
    @(negedge clk); flush = 1'b0; #1;
    checks++;
    if ({out_valid, out_last, in_ready} !== 3'b001) begin
      errors++; $display("FAIL flush_kill: got v=%b l=%b r=%b want 0 0 1", out_valid, out_last, in_ready);
    end
    in_valid = 1'b1; in_instr = 16'h1ABC; in_pc = 16'h0510;
    @(negedge clk); in_valid = 1'b0; #1;
    checks++;
    if ({out_valid, out_last, out_instr, out_pc} !== {2'b11, 16'h1ABC, 16'h0510}) begin
      errors++; $display("FAIL flush_next: got v=%b l=%b i=%h pc=%h want 1 1 1abc 0510", out_valid, out_last, out_instr, out_pc);
    end
    @(negedge clk); flush = 1'b1; #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", in_ready); end
    @(negedge clk); flush = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk); in_valid = 1'b1; in_instr = 16'h67FF; in_pc = 16'h0600;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); #2; rst_n = 1'b0; #1;
    checks++;
    if ({out_valid, out_last, out_instr, out_pc, in_ready} !== 35'd1) begin
      errors++; $display("FAIL async_reset: got v=%b l=%b i=%h pc=%h r=%b want 0 0 0000 0000 1", out_valid, out_last, out_instr, out_pc, in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++; $display("FAIL async_after: got v=%b r=%b want 0 1", out_valid, in_ready);
    end
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] v;
    int sel, opc;
    v = 16'($urandom);
    sel = $urandom_range(0, 3);
    if (sel == 0) begin
      opc = $urandom_range(0, 13);
      if (opc >= 6) opc += 2;
      v[15:12] = 4'(opc);
    end else begin
      v[15:12] = (sel == 1) ? 4'h6 : 4'h7;
      sel = $urandom_range(0, 9);
      if (sel == 0) v[7:0] = 8'h00;
      else if (sel <= 2) v[7:0] = 8'hFF;
    end
    return v;
  endfunction

  task automatic test_random(input int cycles);
    logic exp_ready, drive;
    q.delete();
    for (int c = 0; c < cycles + 40; c++) begin
      drive = (c < cycles);
      @(negedge clk);
      stall    = drive && ($urandom_range(0, 99) < 30);
      flush    = drive && ($urandom_range(0, 99) < 2);
      in_valid = drive && ($urandom_range(0, 99) < 70);
      in_instr = rand_instr();
      in_pc    = 16'($urandom);
      #1;
      exp_ready = !flush && (q.size() == 0 || (!stall && !q[0].lmsm));
      checks++;
      if (in_ready !== exp_ready) begin
        errors++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, in_ready, exp_ready);
      end
      checks++;
      if (out_valid !== (q.size() != 0)) begin
        errors++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, out_valid, (q.size() != 0));
      end
      if (q.size() != 0 && out_valid === 1'b1) begin
        checks++;
        if ({out_instr, out_pc, out_last} !== {q[0].instr, q[0].pc, q[0].last}) begin
          errors++; $display("FAIL rnd_uop c=%0d: got i=%h pc=%h l=%b want i=%h pc=%h l=%b",
                             c, out_instr, out_pc, out_last, q[0].instr, q[0].pc, q[0].last);
        end
      end
      if (flush) q.delete();
      else begin
        if (q.size() != 0 && !stall) void'(q.pop_front());
        if (in_valid && exp_ready) push_expansion(in_instr, in_pc);
      end
    end
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL rnd_drain: got %0d pending want 0", q.size()); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = 16'd0; in_pc = 16'd0; stall = 1'b0; flush = 1'b0;
    test_reset();
    test_passthrough();
    test_lm_basic();
    test_sm_stall();
    test_base_overlap();
    test_zero_mask();
    test_flush();
    test_async_reset();
    test_random(4000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lmsm_expander.md
Name: lmsm_expander

Overview:
- Decode-front stage between the IF/ID pipeline register and the combinational control decoder.
- Passes ordinary instructions through unchanged.
- Expands each LM/SM into a sequence of single-register LW/SW micro-instructions, which the downstream decoder handles natively.
- Back-pressures fetch while an expansion is in progress.

Parameters:
- None; ISA widths are fixed: 16-bit instruction, 16-bit PC, 8 registers.

Ports:
- clk       in   1   clock; all state updates on rising edge.
- rst_n     in   1   reset; asynchronous assert, active-low.
- in_valid  in   1   IF/ID holds a valid instruction.
- in_instr  in   16  instruction from IF/ID.
- in_pc     in   16  PC of in_instr.
- in_ready  out  1   instruction accepted this cycle; 0 = fetch/IF-ID must hold.
- out_valid out  1   out_instr valid toward the decoder / ID-RR register.
- out_instr out  16  pass-through instruction or synthesized LW/SW.
- out_pc    out  16  PC of the originating instruction.
- out_last  out  1   final (or only) micro-op of the originating instruction.
- stall     in   1   downstream hold; output registers must not change.
- flush     in   1   synchronous kill, e.g. branch mispredict.

Behaviour:
- Reset (rst_n=0, asynchronous): out_valid=0, out_instr=0, out_pc=0, out_last=0, state=IDLE, mask=0, offset counter=0.
  - in_ready is combinational, so it reads 1 during reset.
- Instruction fields: opcode=[15:12], RA=[11:9], imm8=[7:0]. LM=0110, SM=0111. Mask bit i selects register Ri.
- Handshake:
  - Output fire = out_valid & ~stall.
  - in_ready = (state==IDLE) & (~out_valid | ~stall).
  - Accept = in_valid & in_ready.
- States: IDLE and EXPAND.
- IDLE, accept, non-LM/SM:
  - Next edge: out_instr=in_instr, out_pc=in_pc, out_valid=1, out_last=1.
  - Latency 1 cycle.
- IDLE, accept, LM/SM with imm8==0:
  - Instruction consumed; out_valid=0 next cycle.
  - No memory op; stays IDLE.
- IDLE, accept, LM/SM with imm8!=0:
  - Latch base=RA, kind (LM/SM), remaining mask=imm8, pc.
  - First micro-op goes to the outputs on the same edge; state becomes EXPAND.
- Micro-op encoding: {op, Ri, base, 3'b000, off[2:0]}.
  - op = 0100 (LW) for LM, 0101 (SW) for SM.
  - Ri = lowest set bit of the remaining mask.
  - off = number of bits set in the original imm8 below index i. This is the memory slot; the address is base+off.
- EXPAND, on output fire:
  - Clear the emitted bit.
  - If bits remain: load the next micro-op; out_last=1 when it is the final one.
  - Else: out_valid=0, state=IDLE.
- EXPAND, no fire: all outputs and state held.
- in_ready=0 throughout EXPAND. One bubble cycle always follows the last micro-op before the next accept.
- An 8-bit mask yields 8 micro-ops (offsets 0..7); off never exceeds 7.
- flush=1 (synchronous): out_valid=0, out_last=0, state=IDLE, mask=0; in_ready forced to 0 that cycle.
  - flush dominates stall and accept.
- rst_n asserted mid-expansion: immediate return to reset values; the partial sequence is abandoned.

Optional Feature:
- Macro: LMSM_BASE_LAST_EN.
- Defined: for LM with imm8[RA]=1, the base-register load is deferred and emitted last.
  - It keeps its natural off, so the memory layout is unchanged.
  - All other micro-ops still see the original base value.
  - out_last goes on the deferred op. SM ordering is unaffected.
- Undefined: strict ascending register order. A base overwrite is visible to later micro-ops; this is software's responsibility.

Test Plan:
- Pass-through: ADD 0x1234 accepted -> next cycle out_valid=1, out_instr=0x1234, out_last=1, in_ready=1.
- LM 0x640B (base R2, mask 0x0B), no stall -> outputs 0x4080, 0x4281, 0x4682 on consecutive cycles; out_last only on 0x4682; in_ready=0 for 3 cycles then 1.
- SM 0x7280 with stall=1 for 2 cycles -> out_instr=0x5E40, out_last=1, held stable during stall; in_ready stays 0 until a cycle after fire.
- LM 0x6207 (base R1, mask 0x07):
  - without macro -> 0x4040, 0x4241, 0x4442.
  - with LMSM_BASE_LAST_EN -> 0x4040, 0x4442, 0x4241.
- LM 0x6400 (zero mask) -> out_valid stays 0; in_ready=1 next cycle; following ADD passes normally.
- flush=1 during the second micro-op of 0x640B -> out_valid=0 next cycle, state IDLE; next accepted instruction emitted normally. Separately, rst_n low mid-sequence -> all outputs 0 immediately.
